// File: rtl/rv_types.sv
// rv_types: shared scalar types and the data-bus arbiter owner encoding.
package rv_types;
    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;
    typedef logic [7:0]  u8_t;
    typedef enum logic {OWN_CORE, OWN_EXT} dbus_owner_t;
endpackage

// File: rtl/rv_dbus_rr.sv
// rv_dbus_rr: round-robin grant with bounded burst hold for two masters.
module rv_dbus_rr
    import rv_types::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       xreset,
    input  logic       req0,
    input  logic       req1,
    input  logic       accept,
    output logic       grant0,
    output logic       grant1,
    output logic       owner,
    output logic [7:0] bcnt
);
    localparam u8_t MAXB = u8_t'(MAX_BURST);
    dbus_owner_t own;
    dbus_owner_t winner;
    logic in_burst;
    assign in_burst = bcnt < MAXB;
    // Under contention the owner keeps the bus until its burst budget is spent.
    assign grant1 = req1 & (!req0 | (in_burst ? own == OWN_EXT : own == OWN_CORE));
    assign grant0 = req0 & !grant1;
    assign winner = grant1 ? OWN_EXT : OWN_CORE;
    assign owner  = own;
    always_ff @(posedge clk) begin
        if (!xreset) begin
            own  <= OWN_CORE;
            bcnt <= 8'd0;
        end else if (accept) begin
            if (winner == own) begin
                bcnt <= (bcnt != 8'hFF) ? bcnt + 8'd1 : bcnt;
            end else begin
                own  <= winner;
                bcnt <= 8'd1;
            end
        end else if (!(own == OWN_EXT ? req1 : req0)) begin
            bcnt <= 8'd0;
        end
    end
endmodule

// File: rtl/rv_dbus_arb.sv
// rv_dbus_arb: two-master data-bus arbiter forwarding the winner to one slave port.
// Stall statistics counters are built only when RV_DBUS_ARB_STAT_EN is defined.
module rv_dbus_arb
    import rv_types::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [31:0] c_adr,
    input  logic [3:0]  c_we,
    input  logic [31:0] c_dw,
    input  logic        c_re,
    output logic [31:0] c_dr,
    output logic        c_rdy,
    input  logic [31:0] m_adr,
    input  logic [3:0]  m_we,
    input  logic [31:0] m_dw,
    input  logic        m_re,
    output logic [31:0] m_dr,
    output logic        m_rdy,
    output logic        m_rvalid,
    output logic [31:0] s_adr,
    output logic [3:0]  s_we,
    output logic [31:0] s_dw,
    output logic        s_re,
    input  logic [31:0] s_dr,
    input  logic        s_rdy,
    output logic [15:0] stall0,
    output logic [15:0] stall1
);
    logic req0, req1, grant0, grant1, g0, g1, accept, owner;
    logic [7:0] bcnt;
    assign req0 = c_re | (c_we != 4'd0);
    assign req1 = m_re | (m_we != 4'd0);
    // Reset masks the grants so nothing reaches the slave while state is cleared.
    assign g0     = grant0 & xreset;
    assign g1     = grant1 & xreset;
    assign accept = (g0 | g1) & s_rdy;
    rv_dbus_rr #(.MAX_BURST(MAX_BURST)) u_rr (
        .clk(clk), .xreset(xreset), .req0(req0), .req1(req1), .accept(accept),
        .grant0(grant0), .grant1(grant1), .owner(owner), .bcnt(bcnt)
    );
    assign s_adr = g1 ? m_adr : c_adr;
    assign s_dw  = g1 ? m_dw : c_dw;
    assign s_we  = g1 ? m_we : (g0 ? c_we : 4'd0);
    assign s_re  = g1 ? m_re : (g0 & c_re);
    assign c_rdy = g0 & s_rdy;
    assign m_rdy = g1 & s_rdy;
    assign c_dr  = s_dr;
    assign m_dr  = s_dr;
    always_ff @(posedge clk) begin
        m_rvalid <= xreset & m_rdy & m_re;
    end
`ifdef RV_DBUS_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (!xreset) begin
            stall0 <= 16'd0;
            stall1 <= 16'd0;
        end else begin
            if (req0 && !g0 && g1 && stall0 != 16'hFFFF) stall0 <= stall0 + 16'd1;
            if (req1 && !g1 && g0 && stall1 != 16'hFFFF) stall1 <= stall1 + 16'd1;
        end
    end
`else
    assign stall0 = 16'd0;
    assign stall1 = 16'd0;
`endif
endmodule

// File: doc/rv_dbus_arb.md
# rv_dbus_arb

Two-master arbiter for the shared data-side memory/peripheral port in the rv32emc SoC top. Master 0 is the `rv_core` data bus; master 1 is a secondary bus master such as a DMA engine or serial program loader. The winning request is forwarded unregistered to the single slave port that drives the dpram port B and the peripheral decode. The loser is stalled through its `rdy`. Arbitration is round-robin with a bounded burst hold, so neither master can starve the other.

## Interface
Parameters:
- `MAX_BURST`, default 4: consecutive accepted transfers the current owner may make while the other master waits. Range 1..255; 1 gives strict alternation under contention.

Ports:
- `clk` in 1: clock.
- `xreset` in 1: reset, synchronous, active-low.
- `c_adr` in 32: master 0 (core) address.
- `c_we` in 4: master 0 byte write enables.
- `c_dw` in 32: master 0 write data.
- `c_re` in 1: master 0 read enable.
- `c_dr` out 32: master 0 read data.
- `c_rdy` out 1: master 0 ready (transfer accepted this cycle).
- `m_adr` in 32: master 1 address.
- `m_we` in 4: master 1 byte write enables.
- `m_dw` in 32: master 1 write data.
- `m_re` in 1: master 1 read enable.
- `m_dr` out 32: master 1 read data.
- `m_rdy` out 1: master 1 ready.
- `m_rvalid` out 1: master 1 read data valid.
- `s_adr` out 32: slave address.
- `s_we` out 4: slave byte write enables.
- `s_dw` out 32: slave write data.
- `s_re` out 1: slave read enable.
- `s_dr` in 32: slave read data.
- `s_rdy` in 1: slave ready.
- `stall0` out 16: master 0 contention stall count (see Configuration).
- `stall1` out 16: master 1 contention stall count (see Configuration).

## Operation
- Request: `reqN = reN | (weN != 0)`. A master holds its request and address/data stable until its `rdy` is high.
- Grant is combinational from `req0`, `req1`, registered `owner` (0/1) and registered `bcnt` (8 bit):
  - only one master requesting: that master wins;
  - both requesting: `owner` wins if `bcnt < MAX_BURST`, otherwise the other master wins;
  - neither requesting: no grant.
- Forwarding:
  - the winner's `adr`/`we`/`dw`/`re` drive the `s_*` outputs;
  - with no grant, `s_re = 0`, `s_we = 0`, and `s_adr`/`s_dw` hold master 0's values.
- Ready:
  - `c_rdy = grant0 & s_rdy`;
  - `m_rdy = grant1 & s_rdy`;
  - the losing master's `rdy` is 0.
- Accept means grant & `s_rdy`. On accept:
  - if the winner equals `owner`, `bcnt` increments, saturating at 255;
  - otherwise `owner` becomes the winner and `bcnt` becomes 1.
- If `owner` drops its request for a cycle, `bcnt` clears to 0 and `owner` is unchanged.
- Read return:
  - slave read data is valid the cycle after an accepted read;
  - `s_dr` is broadcast unmodified to both `c_dr` and `m_dr`;
  - `m_rvalid` pulses 1 cycle after an accepted master-1 read;
  - master 0 uses its fixed next-cycle convention.
- Write + read in the same request is forwarded as-is; the slave defines the semantics.

## Timing
- Reset (`xreset` low at a clock edge):
  - `owner = 0`, `bcnt = 0`, `m_rvalid = 0`, `stall0`/`stall1 = 0`;
  - all `s_we`/`s_re` and both `rdy` are forced 0 during reset, regardless of requests.
- Uncontested access adds zero cycles: grant and `rdy` are in the same cycle as the request when `s_rdy = 1`.
- Read latency is 1 cycle from accept to data, unchanged by the arbiter.
- Contention, `MAX_BURST = 4`, both masters requesting continuously: owner gets 4 accepts, other gets 4, repeating. No cycle is ever idle while a request is pending and `s_rdy = 1`.
- `s_rdy` low: no accept, `owner`/`bcnt` hold, grant may still change if requests change.
- Reset asserted mid-burst aborts the arbitration state; a pending `m_rvalid` is dropped.

## Configuration
- `RV_DBUS_ARB_STAT_EN` defined:
  - `stall0`/`stall1` are 16-bit saturating counters (stop at 0xFFFF);
  - each increments on every cycle its master requests and is not granted while the other master is granted;
  - both clear on reset.
- `RV_DBUS_ARB_STAT_EN` undefined: counters are not built and `stall0`/`stall1` are tied to 0.

## Structure
- Shared `rv_types` package: reuse `u32_t`, `u4_t`, `u8_t`; add `typedef enum logic {OWN_CORE, OWN_EXT} dbus_owner_t`.
- One sub-module, `rv_dbus_rr`: the grant/`owner`/`bcnt` logic (inputs `req0`, `req1`, accept; outputs `grant0`, `grant1`). The mux and read-return logic stay in the top.

## Test plan
- Core only, read at 0x100, `s_rdy = 1`: `c_rdy = 1` in the same cycle, `s_adr = 0x100`, `c_dr` equals `s_dr` the next cycle, `m_rdy = 0` throughout.
- Both masters request continuously, `MAX_BURST = 4`, `owner = 0` after reset: accept sequence 0,0,0,0,1,1,1,1,0…
- `MAX_BURST = 1`, continuous contention: strict alternation; `stall0` and `stall1` each increase by 1 every 2 cycles (STAT_EN defined).
- Master 1 read at 0x2000 while the core is idle: `m_rdy = 1` in the same cycle, `m_rvalid = 1` exactly 1 cycle later with `m_dr = s_dr`.
- `s_rdy` held 0 for 3 cycles under contention: no accepts, `bcnt`/`owner` unchanged, `s_we` stable; first accept after `s_rdy` rises goes to the same winner.
- `xreset` low during the 3rd beat of a master-1 burst: next cycle all `rdy`/`s_re`/`s_we` are 0; after release, a lone core request is granted with `bcnt = 1`.
